// File: rtl/mc_stream_pkg.sv
// Shared types, width helpers and arbitration search functions for the
// multi-channel stream arbiter.
package mc_stream_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam int MAX_CH      = 16;
   localparam int NUM_CH_DFLT = 4;
   localparam int DEPTH_DFLT  = 4;

   function automatic int calc_ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int calc_lvl_w(input int d);
      return $clog2(d + 1);
   endfunction

   localparam int CH_W_DFLT  = calc_ch_w(NUM_CH_DFLT);
   localparam int LVL_W_DFLT = calc_lvl_w(DEPTH_DFLT);

   // First requester found at or after last+1, wrapping modulo n.
   // Iterating from the far end lets the nearest candidate win.
   // Returns last when nothing requests.
   function automatic int unsigned rr_next(input logic [MAX_CH-1:0] req,
                                           input int unsigned last,
                                           input int unsigned n);
      int unsigned cand;
      rr_next = last;
      for (int unsigned k = MAX_CH; k >= 1; k--) begin
         cand = (last + k) % n;
         if (k <= n && req[cand[3:0]]) begin
            rr_next = cand;
         end
      end
   endfunction

   // Lowest-index requester among the first n bits; 0 when nothing requests.
   function automatic int unsigned prio_next(input logic [MAX_CH-1:0] req,
                                             input int unsigned n);
      prio_next = 0;
      for (int unsigned k = MAX_CH; k >= 1; k--) begin
         if ((k - 1) < n && req[4'(k - 1)]) begin
            prio_next = k - 1;
         end
      end
   endfunction

endpackage

// File: rtl/mc_stream_arbiter_fifo.sv
// Single-clock per-channel FIFO with an explicit 0..DEPTH level counter so
// full and empty never alias.
module ch_sync_fifo
   import mc_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              rd_en,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic [calc_lvl_w(DEPTH)-1:0]      level,
   output logic                              full,
   output logic                              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = calc_lvl_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  do_wr, do_rd;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A full FIFO refuses writes even when it is popped in the same cycle.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/mc_stream_arbiter.sv
// Merges NUM_CH buffered valid/ready streams onto one registered output
// stream tagged with its source channel; round-robin or fixed priority.
module mc_stream_arbiter
   import mc_stream_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      data_in_vld,
   input  logic [NUM_CH*DATA_WIDTH-1:0]           data_in,
   output logic [NUM_CH-1:0]                      data_in_rdy,
   output logic                                   data_out_vld,
   output logic [DATA_WIDTH-1:0]                  data_out,
   output logic [calc_ch_w(NUM_CH)-1:0]           data_out_ch,
   input  logic                                   data_out_rdy,
   output logic [NUM_CH*calc_lvl_w(DEPTH)-1:0]    fifo_level
);

   localparam int CH_W  = calc_ch_w(NUM_CH);
   localparam int LVL_W = calc_lvl_w(DEPTH);

   logic [NUM_CH-1:0]     fifo_full;
   logic [NUM_CH-1:0]     fifo_empty;
   logic [NUM_CH-1:0]     fifo_wr_en;
   logic [NUM_CH-1:0]     fifo_rd_en;
   logic [NUM_CH-1:0]     fifo_nonempty;
   logic [DATA_WIDTH-1:0] fifo_rd_data [NUM_CH];
   logic [LVL_W-1:0]      fifo_lvl     [NUM_CH];

   logic                  run_q, run_d;
   logic                  out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]       out_ch_q, out_ch_d;
   logic [CH_W-1:0]       last_grant_q, last_grant_d;

   logic [MAX_CH-1:0]     req_pad;
   int unsigned           grant_idx;
   logic [CH_W-1:0]       grant;
   logic                  any_req;
   logic                  load;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ch_sync_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (fifo_wr_en[g]),
         .wr_data (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
         .rd_en   (fifo_rd_en[g]),
         .rd_data (fifo_rd_data[g]),
         .level   (fifo_lvl[g]),
         .full    (fifo_full[g]),
         .empty   (fifo_empty[g])
      );
      assign fifo_level[g*LVL_W +: LVL_W] = fifo_lvl[g];
   end

   // Ready is held low through reset and comes from registered state only,
   // so there is no combinational path from data_out_rdy.
   assign data_in_rdy   = {NUM_CH{run_q}} & ~fifo_full;
   assign fifo_wr_en    = data_in_vld & data_in_rdy;
   assign fifo_nonempty = ~fifo_empty;
   assign any_req       = |fifo_nonempty;
   assign load          = (!out_vld_q || data_out_rdy) && any_req;
   assign run_d         = 1'b1;

   always_comb begin
      req_pad                = '0;
      req_pad[NUM_CH-1:0]    = fifo_nonempty;
      if (ARB_MODE == int'(ARB_FIXED)) begin
         grant_idx = prio_next(req_pad, NUM_CH);
      end else begin
         grant_idx = rr_next(req_pad, 32'(last_grant_q), NUM_CH);
      end
      grant = CH_W'(grant_idx);
   end

   always_comb begin
      fifo_rd_en   = '0;
      out_vld_d    = out_vld_q;
      out_data_d   = out_data_q;
      out_ch_d     = out_ch_q;
      last_grant_d = last_grant_q;
      if (load) begin
         fifo_rd_en[grant] = 1'b1;
         out_vld_d         = 1'b1;
         out_data_d        = fifo_rd_data[grant];
         out_ch_d          = grant;
         last_grant_d      = grant;
      end else if (data_out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q        <= 1'b0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         last_grant_q <= CH_W'(NUM_CH - 1);
      end else begin
         run_q        <= run_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign data_out_vld = out_vld_q;
   assign data_out     = out_data_q;
   assign data_out_ch  = out_ch_q;

endmodule

// File: tb/tb_mc_stream_arbiter.sv
// Two arbiter instances (round-robin and fixed priority) driven by the same
// stimulus; per-instance scoreboards are checked by a negedge monitor.
module tb_mc_stream_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  vld;
   logic [31:0] din;
   logic        out_rdy;

   logic [3:0]  in_rdy   [2];
   logic        out_vld  [2];
   logic [7:0]  out_data [2];
   logic [1:0]  out_ch   [2];
   logic [11:0] lvl      [2];

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q    [2][4][$];
   int         exp_ch_q [2][$];

   logic       prev_stall [2];
   logic [7:0] prev_data  [2];
   logic [1:0] prev_ch    [2];

   always #5 clk = ~clk;

   mc_stream_arbiter #(.NUM_CH(4), .DATA_WIDTH(8), .DEPTH(4), .ARB_MODE(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .data_in_vld(vld), .data_in(din),
      .data_in_rdy(in_rdy[0]), .data_out_vld(out_vld[0]), .data_out(out_data[0]),
      .data_out_ch(out_ch[0]), .data_out_rdy(out_rdy), .fifo_level(lvl[0]));

   mc_stream_arbiter #(.NUM_CH(4), .DATA_WIDTH(8), .DEPTH(4), .ARB_MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .data_in_vld(vld), .data_in(din),
      .data_in_rdy(in_rdy[1]), .data_out_vld(out_vld[1]), .data_out(out_data[1]),
      .data_out_ch(out_ch[1]), .data_out_rdy(out_rdy), .fifo_level(lvl[1]));

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every output transfer, check stall stability, and
   // record every accepted input word as the expected per-channel order.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) exp_q[d][c].delete();
            exp_ch_q[d].delete();
            prev_stall[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (prev_stall[d]) begin
               check($sformatf("stall_vld[%0d]", d), int'(out_vld[d]), 1);
               check($sformatf("stall_data[%0d]", d), int'(out_data[d]), int'(prev_data[d]));
               check($sformatf("stall_ch[%0d]", d), int'(out_ch[d]), int'(prev_ch[d]));
            end
            if (out_vld[d] && out_rdy) begin
               if (exp_ch_q[d].size() > 0) begin
                  check($sformatf("ch_seq[%0d]", d), int'(out_ch[d]), exp_ch_q[d].pop_front());
               end
               if (exp_q[d][out_ch[d]].size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_word[%0d]: got ch %0d data %0h expected no word",
                           d, out_ch[d], out_data[d]);
               end else begin
                  check($sformatf("out_data[%0d] ch%0d", d, out_ch[d]), int'(out_data[d]),
                        int'(exp_q[d][out_ch[d]].pop_front()));
               end
            end
            prev_stall[d] = out_vld[d] && !out_rdy;
            prev_data[d]  = out_data[d];
            prev_ch[d]    = out_ch[d];
            for (int c = 0; c < 4; c++) begin
               if (vld[c] && in_rdy[d][c]) exp_q[d][c].push_back(din[c*8 +: 8]);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n   = 1'b0;
      vld     = '0;
      out_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic preload3();
      for (int k = 0; k < 3; k++) begin
         vld = 4'hF;
         din = {4'h3, 4'(k), 4'h2, 4'(k), 4'h1, 4'(k), 4'h0, 4'(k)};
         tick();
      end
      vld = '0;
   endtask

   task automatic wait_idle_and_check(input string nm);
      int  k;
      logic busy;
      vld     = '0;
      out_rdy = 1'b1;
      busy    = 1'b1;
      k       = 0;
      while (busy && k < 200) begin
         tick();
         busy = out_vld[0] || out_vld[1] || (lvl[0] != 0) || (lvl[1] != 0);
         k++;
      end
      check({nm, "_drain_done"}, int'(busy), 0);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++)
            check($sformatf("%s_left[%0d][%0d]", nm, d, c), exp_q[d][c].size(), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      logic acc;

      // Reset with all inputs valid
      rst_n   = 1'b0;
      vld     = 4'hF;
      din     = 32'hFFFF_FFFF;
      out_rdy = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_in_rdy[%0d]", d), int'(in_rdy[d]), 0);
         check($sformatf("rst_out_vld[%0d]", d), int'(out_vld[d]), 0);
         check($sformatf("rst_level[%0d]", d), int'(lvl[d]), 0);
      end
      rst_n = 1'b1;
      vld   = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rel_in_rdy[%0d]", d), int'(in_rdy[d]), 4'hF);
         check($sformatf("rel_out_vld[%0d]", d), int'(out_vld[d]), 0);
         check($sformatf("rel_out_data[%0d]", d), int'(out_data[d]), 0);
         check($sformatf("rel_out_ch[%0d]", d), int'(out_ch[d]), 0);
      end

      // Single word on channel 2
      out_rdy      = 1'b1;
      vld          = 4'b0100;
      din[23:16]   = 8'hA5;
      tick();
      vld = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("single_vld[%0d]", d), int'(out_vld[d]), 1);
         check($sformatf("single_data[%0d]", d), int'(out_data[d]), 8'hA5);
         check($sformatf("single_ch[%0d]", d), int'(out_ch[d]), 2);
      end
      tick();

      // Arbitration order: round-robin vs fixed priority on identical preload
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) exp_ch_q[0].push_back(c);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 3; r++) exp_ch_q[1].push_back(c);
      preload3();
      out_rdy = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         check("arb_no_gap_rr", int'(out_vld[0]), 1);
         check("arb_no_gap_fp", int'(out_vld[1]), 1);
         tick();
      end
      @(negedge clk);
      check("arb_end_vld_rr", int'(out_vld[0]), 0);
      check("arb_end_vld_fp", int'(out_vld[1]), 0);
      check("arb_seq_left_rr", exp_ch_q[0].size(), 0);
      check("arb_seq_left_fp", exp_ch_q[1].size(), 0);

      // Full FIFO with output backpressure
      do_reset();
      i = 0;
      for (int n = 0; n < 6; n++) begin
         vld       = 4'b0010;
         din[15:8] = 8'h40 + 8'(i);
         acc       = in_rdy[0][1];
         tick();
         if (acc) i++;
      end
      check("full_accepted", i, 5);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("full_level[%0d]", d), int'(lvl[d][5:3]), 4);
         check($sformatf("full_in_rdy[%0d]", d), int'(in_rdy[d][1]), 0);
         check($sformatf("full_out_data[%0d]", d), int'(out_data[d]), 8'h40);
         check($sformatf("full_out_vld[%0d]", d), int'(out_vld[d]), 1);
      end
      repeat (3) tick();
      check("full_hold_data", int'(out_data[0]), 8'h40);
      out_rdy = 1'b1;
      for (int n = 0; n < 10 && i < 6; n++) begin
         acc = in_rdy[0][1];
         tick();
         if (acc) i++;
      end
      check("full_last_accepted", i, 6);
      wait_idle_and_check("full");

      // Reset during a draining burst
      do_reset();
      preload3();
      out_rdy = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("midrst_vld[%0d]", d), int'(out_vld[d]), 0);
         check($sformatf("midrst_level[%0d]", d), int'(lvl[d]), 0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         check("midrst_no_stale_rr", int'(out_vld[0]), 0);
         check("midrst_no_stale_fp", int'(out_vld[1]), 0);
      end

      // Random traffic with random downstream ready
      for (int n = 0; n < 400; n++) begin
         vld     = 4'($urandom);
         din     = $urandom;
         out_rdy = ($urandom_range(0, 9) < 6);
         tick();
      end
      wait_idle_and_check("rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
